move_deque: RTL and testbench
=============================

Name: move_deque

Overview:
- Parametrised successor to the maze-path move store.
- Single circular buffer supporting three operations:
  - LIFO pop from the newest end, for backtracking.
  - FIFO pop (qpop) from the oldest end, for replaying the solved path.
  - Push at the newest end.
- Adds count, full/empty flags, a registered output with valid, defined simultaneous-operation rules, a sticky error and a clear.
- Sits between the maze controller FSM and the move decoder / move output.

Parameters:
- DATA_W, 2, width of one stored entry (direction code).
- DEPTH, 256, number of entries; must be a power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of contents and error state.
- push  input  1  write data_in at the newest end.
- pop  input  1  remove the newest entry (LIFO).
- qpop  input  1  remove the oldest entry (FIFO).
- data_in  input  DATA_W  entry to push.
- data_out  output  DATA_W  removed entry, registered.
- out_valid  output  1  one-cycle pulse: data_out holds a removed entry.
- count  output  PTR_W+1  entries held, 0..DEPTH.
- empty  output  1  count == 0, combinational from state.
- full  output  1  count == DEPTH, combinational from state.
- err  output  1  one-cycle pulse on an illegal operation.
- err_sticky  output  1  set by any err pulse; cleared by rst or clear.

Behaviour:
- Reset (rst high at the edge), and likewise clear:
  - head = 0, tail = 0, count = 0.
  - data_out = 0, out_valid = 0, err = 0, err_sticky = 0.
  - Memory contents are don't-care.
  - rst has priority over clear and over every operation. rst asserted mid-sequence discards everything.
  - clear has priority over push/pop/qpop.
- Pointers:
  - head points to the oldest entry; tail points to the next free slot.
  - Newest entry is at tail-1.
  - All pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- Latency: a removal presented at edge N drives data_out and out_valid=1 after edge N, i.e. valid for cycle N+1. out_valid is 0 in every cycle with no removal.
- data_out holds its last value when out_valid=0.
- Operation table, evaluated at each edge (exactly one row applies):
  - none: no change.
  - push only, not full: mem[tail] <= data_in; tail+1; count+1.
  - push only, full: err; no state change.
  - pop only, not empty: data_out <= mem[tail-1]; tail-1; count-1; out_valid.
  - qpop only, not empty: data_out <= mem[head]; head+1; count-1; out_valid.
  - pop or qpop only, empty: err; out_valid=0; no state change.
  - push+pop, not empty (swap top):
    - data_out <= mem[tail-1]; mem[tail-1] <= data_in; out_valid.
    - Pointers and count unchanged. Legal even when full.
  - push+qpop, not empty:
    - data_out <= mem[head]; mem[tail] <= data_in; head+1; tail+1; out_valid.
    - count unchanged. Legal when full: the slot freed at head equals tail.
  - push+pop or push+qpop, empty (pass-through): data_out <= data_in; out_valid; count stays 0.
  - pop+qpop (with or without push): err; no state change, no write, out_valid=0.
- err is a single-cycle pulse in the cycle after the offending edge. err_sticky is set on the same edge.
- count, empty and full always agree; full and empty are never both 1 (DEPTH >= 2).

Decomposition:
- Shared package maze_pkg holds:
  - Direction codes: DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11.
  - A dir_t typedef of width 2.
  - These are used by the deque, the controller and the decoder.
- One natural sub-module: move_deque_mem.
  - DEPTH x DATA_W synchronous-write array.
  - One write port and one combinational read port.
  - The top level muxes the read address between head and tail-1.
- Pointer/count logic and the operation decode stay in move_deque.

Test Plan:
- Reset/LIFO:
  - Stimulus: rst, then push 00, 01, 10, 11; pop x4; then one further pop.
  - Response: data_out 11, 10, 01, 00, each with out_valid one cycle after its pop; then err=1, err_sticky=1, count=0, empty=1.
- FIFO replay:
  - Stimulus: push 01, 10, 11; qpop x3.
  - Response: data_out 01, 10, 11; count goes 3 -> 0; no err.
- Full and wrap (DEPTH=4 instance):
  - Stimulus: push x4, then push, then qpop x2, push x2, qpop x4.
  - Response: full=1 after the 4th push; 5th push gives err with count=4; pointers wrap and the FIFO order is preserved.
- Simultaneous ops:
  - Stimulus: holding [00, 01], assert push(11)+pop.
  - Response: data_out 01, contents [00, 11], count 2.
  - Stimulus: with the deque full, assert push(10)+qpop.
  - Response: oldest entry out, count stays DEPTH, no err.
- Empty pass-through and conflict:
  - Stimulus: empty, push(10)+qpop.
  - Response: data_out 10, out_valid, count 0.
  - Stimulus: pop+qpop together.
  - Response: err, no state change.
- Clear/reset mid-operation:
  - Stimulus: 3 entries held, err_sticky=1; assert clear together with push.
  - Response: count 0, err_sticky 0, push ignored.
  - Stimulus: assert rst during a qpop.
  - Response: out_valid 0, count 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Direction codes shared by the maze controller, move deque and move decoder.
package maze_pkg;

  localparam int unsigned DIR_W = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_DOWN  = 2'b11;

endpackage

// File: rtl/move_deque_pkg.sv
// Operation encoding and decode for the move deque.
package move_deque_pkg;

  import maze_pkg::*;

  typedef enum logic [2:0] {
    OpNone,
    OpPush,
    OpPop,
    OpQpop,
    OpSwap,
    OpPushQpop,
    OpPass,
    OpErr
  } op_e;

  // Resolves the request bits and occupancy to exactly one operation.
  function automatic op_e decode_op(input logic push, input logic pop, input logic qpop,
                                    input logic empty, input logic full);
    op_e op;
    unique case ({push, pop, qpop})
      3'b000:  op = OpNone;
      3'b100:  op = full  ? OpErr  : OpPush;
      3'b010:  op = empty ? OpErr  : OpPop;
      3'b001:  op = empty ? OpErr  : OpQpop;
      3'b110:  op = empty ? OpPass : OpSwap;
      3'b101:  op = empty ? OpPass : OpPushQpop;
      default: op = OpErr;  // pop and qpop together, with or without push
    endcase
    return op;
  endfunction

endpackage

// File: rtl/move_deque_if.sv
// Request/response bundle between the maze controller and the move deque.
interface move_deque_if
  import move_deque_pkg::*;
#(
  parameter int unsigned DATA_W = maze_pkg::DIR_W,
  parameter int unsigned DEPTH  = 256
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              clear;
  logic              push;
  logic              pop;
  logic              qpop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              err;
  logic              err_sticky;

  modport master (
    output clear, push, pop, qpop, data_in,
    input  data_out, out_valid, count, empty, full, err, err_sticky
  );

  modport slave (
    input  clear, push, pop, qpop, data_in,
    output data_out, out_valid, count, empty, full, err, err_sticky
  );

endinterface

// File: rtl/move_deque_mem.sv
// Storage array: synchronous write, combinational read, no reset.
module move_deque_mem
  import move_deque_pkg::*;
#(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/move_deque.sv
// Circular move store: push/pop at the newest end, qpop from the oldest end.
module move_deque
  import maze_pkg::*;
  import move_deque_pkg::*;
#(
  parameter int unsigned DATA_W = DIR_W,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  move_deque_if.slave  bus_io
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  tail_m1;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;

  logic              empty, full;
  logic              we;
  logic [PTR_W-1:0]  waddr, raddr;
  logic [DATA_W-1:0] rdata;
  op_e               op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign tail_m1 = tail_q - 1'b1;
  assign op      = decode_op(bus_io.push, bus_io.pop, bus_io.qpop, empty, full);
  assign raddr   = (op == OpPop || op == OpSwap) ? tail_m1 : head_q;

  move_deque_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .wdata_i (bus_io.data_in),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    we           = 1'b0;
    waddr        = tail_q;

    if (bus_io.clear) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      data_out_d   = '0;
      err_sticky_d = 1'b0;
    end else begin
      unique case (op)
        OpNone: ;
        OpPush: begin
          we      = 1'b1;
          tail_d  = tail_q + 1'b1;
          count_d = count_q + 1'b1;
        end
        OpPop: begin
          data_out_d  = rdata;
          out_valid_d = 1'b1;
          tail_d      = tail_m1;
          count_d     = count_q - 1'b1;
        end
        OpQpop: begin
          data_out_d  = rdata;
          out_valid_d = 1'b1;
          head_d      = head_q + 1'b1;
          count_d     = count_q - 1'b1;
        end
        // Top entry is read combinationally before the edge overwrites it.
        OpSwap: begin
          data_out_d  = rdata;
          out_valid_d = 1'b1;
          we          = 1'b1;
          waddr       = tail_m1;
        end
        // When full, tail == head: the old value is read out as the new one lands.
        OpPushQpop: begin
          data_out_d  = rdata;
          out_valid_d = 1'b1;
          we          = 1'b1;
          head_d      = head_q + 1'b1;
          tail_d      = tail_q + 1'b1;
        end
        OpPass: begin
          data_out_d  = bus_io.data_in;
          out_valid_d = 1'b1;
        end
        OpErr: begin
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus_io.data_out   = data_out_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.count      = count_q;
  assign bus_io.empty      = empty;
  assign bus_io.full       = full;
  assign bus_io.err        = err_q;
  assign bus_io.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_move_deque.sv
// Table-driven bench for move_deque (DEPTH=4) with a removal scoreboard.
module tb_move_deque;

  import maze_pkg::*;

  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  move_deque_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  move_deque #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    string       tag;
    logic        r;
    logic        c;
    logic        pu;
    logic        po;
    logic        qp;
    dir_t        din;
    logic        v;
    dir_t        d;
    logic        e;
    logic        s;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];
  dir_t exp_q[$];
  dir_t last_d;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string tag, input logic r, input logic c, input logic pu,
                     input logic po, input logic qp, input dir_t din, input logic v,
                     input dir_t d, input logic e, input logic s, input int unsigned cnt);
    vec_t x;
    x.tag = tag; x.r = r; x.c = c; x.pu = pu; x.po = po; x.qp = qp; x.din = din;
    x.v = v; x.d = d; x.e = e; x.s = s; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  task automatic check(input string what, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", what, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic pu, input logic po,
                       input logic qp, input dir_t din);
    rst = r; bus.clear = c; bus.push = pu; bus.pop = po; bus.qpop = qp; bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.qpop = 1'b0;
    bus.data_in = '0;
    last_d = '0;

    //   tag          r  c  pu po qp din    v  d      e  s  cnt
    add("reset",      1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    add("push00",     0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1);
    add("push01",     0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 0, 2);
    add("push10",     0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 0, 3);
    add("push11",     0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0, 4);
    add("lifo1",      0, 0, 0, 1, 0, 2'b00, 1, 2'b11, 0, 0, 3);
    add("lifo2",      0, 0, 0, 1, 0, 2'b00, 1, 2'b10, 0, 0, 2);
    add("lifo3",      0, 0, 0, 1, 0, 2'b00, 1, 2'b01, 0, 0, 1);
    add("lifo4",      0, 0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 0, 0);
    add("pop_empty",  0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0);
    add("fpush01",    0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 1, 1);
    add("fpush10",    0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 1, 2);
    add("fpush11",    0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 1, 3);
    add("fifo1",      0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 0, 1, 2);
    add("fifo2",      0, 0, 0, 0, 1, 2'b00, 1, 2'b10, 0, 1, 1);
    add("fifo3",      0, 0, 0, 0, 1, 2'b00, 1, 2'b11, 0, 1, 0);
    add("wpush00",    0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1);
    add("wpush01",    0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 1, 2);
    add("wpush10",    0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 1, 3);
    add("wpush11",    0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 1, 4);
    add("push_full",  0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, 1, 4);
    add("wq1",        0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 1, 3);
    add("wq2",        0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 0, 1, 2);
    add("wpush00b",   0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 1, 3);
    add("wpush01b",   0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 1, 4);
    add("full_pq",    0, 0, 1, 0, 1, 2'b10, 1, 2'b10, 0, 1, 4);
    add("wq3",        0, 0, 0, 0, 1, 2'b00, 1, 2'b11, 0, 1, 3);
    add("wq4",        0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 1, 2);
    add("wq5",        0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 0, 1, 1);
    add("wq6",        0, 0, 0, 0, 1, 2'b00, 1, 2'b10, 0, 1, 0);
    add("spush00",    0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1);
    add("spush01",    0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 1, 2);
    add("swap",       0, 0, 1, 1, 0, 2'b11, 1, 2'b01, 0, 1, 2);
    add("swap_top",   0, 0, 0, 1, 0, 2'b00, 1, 2'b11, 0, 1, 1);
    add("swap_bot",   0, 0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 1, 0);
    add("pass_q",     0, 0, 1, 0, 1, 2'b10, 1, 2'b10, 0, 1, 0);
    add("pass_p",     0, 0, 1, 1, 0, 2'b01, 1, 2'b01, 0, 1, 0);
    add("cpush11",    0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 1, 1);
    add("pop_qpop",   0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 1, 1, 1);
    add("all_three",  0, 0, 1, 1, 1, 2'b00, 0, 2'b00, 1, 1, 1);
    add("after_conf", 0, 0, 0, 0, 1, 2'b00, 1, 2'b11, 0, 1, 0);
    add("kpush01",    0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 1, 1);
    add("kpush10",    0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 1, 2);
    add("kpush11",    0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 0, 1, 3);
    add("clr_push",   0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    add("post_clr",   0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1, 1, 0);
    add("clear",      0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    add("rpush01",    0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 0, 1);
    add("rpush10",    0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 0, 2);
    add("rst_qpop",   1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0);
    add("post_rst",   0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0);
    add("reset2",     1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].v) exp_q.push_back(vecs[i].d);
      drive(vecs[i].r, vecs[i].c, vecs[i].pu, vecs[i].po, vecs[i].qp, vecs[i].din);
      if (vecs[i].r || vecs[i].c) last_d = '0;
      if (vecs[i].v) last_d = vecs[i].d;

      check({vecs[i].tag, " count"}, i, 32'(bus.count), vecs[i].cnt);
      check({vecs[i].tag, " empty"}, i, 32'(bus.empty), 32'(vecs[i].cnt == 0));
      check({vecs[i].tag, " full"}, i, 32'(bus.full), 32'(vecs[i].cnt == DEPTH));
      check({vecs[i].tag, " err"}, i, 32'(bus.err), 32'(vecs[i].e));
      check({vecs[i].tag, " err_sticky"}, i, 32'(bus.err_sticky), 32'(vecs[i].s));
      check({vecs[i].tag, " out_valid"}, i, 32'(bus.out_valid), 32'(vecs[i].v));

      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected removal (step %0d): got %0h, expected none",
                   vecs[i].tag, i, bus.data_out);
        end else begin
          check({vecs[i].tag, " data_out"}, i, 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check({vecs[i].tag, " data_hold"}, i, 32'(bus.data_out), 32'(last_d));
      end
    end

    check("scoreboard drained", 0, exp_q.size(), 0);

    // Pulse widths: out_valid and err last exactly one cycle; data_out holds.
    drive(0, 0, 1, 0, 0, DIR_LEFT);
    drive(0, 0, 0, 0, 1, DIR_UP);
    check("seq qpop valid", 100, 32'(bus.out_valid), 1);
    check("seq qpop data", 100, 32'(bus.data_out), 32'(DIR_LEFT));
    drive(0, 0, 0, 0, 0, DIR_UP);
    check("seq valid pulse", 101, 32'(bus.out_valid), 0);
    check("seq data held", 101, 32'(bus.data_out), 32'(DIR_LEFT));
    drive(0, 0, 0, 1, 0, DIR_UP);
    check("seq err", 102, 32'(bus.err), 1);
    drive(0, 0, 0, 0, 0, DIR_UP);
    check("seq err pulse", 103, 32'(bus.err), 0);
    check("seq sticky held", 103, 32'(bus.err_sticky), 1);
    check("seq count", 103, 32'(bus.count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
